// File: rtl/rf_param.sv
// ---------------------------------------------------------------------------
// rf_param - parametrised register file with two write ports and a
// per-register load-pending scoreboard.
//
// Decode reads operands and issues loads; writeback returns ALU results on
// port A and load data on port B.  A pending bit per register lets decode
// stall on outstanding loads.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   rd_addr / rd_data       NREAD combinational read ports, packed by port
//   rd_pending              per read port: addressed register awaits a load
//   wa_en/wa_addr/wa_data   write port A (ALU writeback)
//   wb_en/wb_addr/wb_data   write port B (load return, clears pending)
//   issue_en/issue_addr     mark a register pending for a new load
//   issue_stall             issue refused, target still pending
//   hazard_err              sticky: port A wrote a register awaiting a load
// ---------------------------------------------------------------------------
module rf_param #(
   parameter int unsigned  WIDTH    = 16,
   parameter int unsigned  DEPTH    = 8,
   parameter int unsigned  NREAD    = 2,
   parameter bit           ZERO_REG = 1'b0,
   parameter bit           BYPASS   = 1'b1,
   localparam int unsigned AW       = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREAD*AW-1:0]    rd_addr,
   output logic [NREAD*WIDTH-1:0] rd_data,
   output logic [NREAD-1:0]       rd_pending,
   input  logic                   wa_en,
   input  logic [AW-1:0]          wa_addr,
   input  logic [WIDTH-1:0]       wa_data,
   input  logic                   wb_en,
   input  logic [AW-1:0]          wb_addr,
   input  logic [WIDTH-1:0]       wb_data,
   input  logic                   issue_en,
   input  logic [AW-1:0]          issue_addr,
   output logic                   issue_stall,
   output logic                   hazard_err
);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] pending_q;
   logic [DEPTH-1:0] pending_d;
   logic             hazard_q;
   logic             hazard_d;

   logic             wb_hits_issue_s;
   logic             wb_hits_wa_s;
   logic             issue_stall_s;
   logic             issue_set_s;
   logic [AW-1:0]    ra_s [NREAD];

   // Issue qualification: a load returning to the same register this cycle
   // frees it, so the new issue may take ownership without stalling.
   always_comb begin
      wb_hits_issue_s = wb_en && (wb_addr == issue_addr);
      wb_hits_wa_s    = wb_en && (wb_addr == wa_addr);
      issue_stall_s   = issue_en && pending_q[issue_addr] && !wb_hits_issue_s;
      // An issue to the hard-wired zero register is accepted but tracks nothing.
      issue_set_s     = issue_en && !issue_stall_s &&
                        !(ZERO_REG && (issue_addr == {AW{1'b0}}));
   end

   // Next-state for storage, scoreboard and sticky hazard flag.
   always_comb begin
      regs_d    = regs_q;
      pending_d = pending_q;
      for (int unsigned r = 0; r < DEPTH; r++) begin
         if (ZERO_REG && (r == 32'd0)) begin
            regs_d[r]    = {WIDTH{1'b0}};
            pending_d[r] = 1'b0;
         end else begin
            // Port B has priority over port A on an address collision.
            if (wb_en && (wb_addr == AW'(r))) begin
               regs_d[r] = wb_data;
            end else if (wa_en && (wa_addr == AW'(r))) begin
               regs_d[r] = wa_data;
            end else begin
               regs_d[r] = regs_q[r];
            end
            // A new issue wins over a same-cycle clear: the new load owns it.
            if (issue_set_s && (issue_addr == AW'(r))) begin
               pending_d[r] = 1'b1;
            end else if (wb_en && (wb_addr == AW'(r))) begin
               pending_d[r] = 1'b0;
            end else begin
               pending_d[r] = pending_q[r];
            end
         end
      end
      if (wa_en && pending_q[wa_addr] && !wb_hits_wa_s) begin
         hazard_d = 1'b1;
      end else begin
         hazard_d = hazard_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < DEPTH; r++) begin
            regs_q[r] <= {WIDTH{1'b0}};
         end
         pending_q <= {DEPTH{1'b0}};
         hazard_q  <= 1'b0;
      end else begin
         regs_q    <= regs_d;
         pending_q <= pending_d;
         hazard_q  <= hazard_d;
      end
   end

   // Unpack the read address bus into one address per port.
   always_comb begin
      for (int unsigned i = 0; i < NREAD; i++) begin
         ra_s[i] = rd_addr[i*AW +: AW];
      end
   end

   // Combinational read ports with optional write-through forwarding.
   always_comb begin
      rd_data    = {(NREAD*WIDTH){1'b0}};
      rd_pending = {NREAD{1'b0}};
      for (int unsigned i = 0; i < NREAD; i++) begin
         // Reset gating keeps bypassed write data off the outputs during reset.
         if (!rst_n) begin
            rd_data[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            rd_pending[i]             = 1'b0;
         end else if (ZERO_REG && (ra_s[i] == {AW{1'b0}})) begin
            rd_data[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            rd_pending[i]             = 1'b0;
         end else if (BYPASS && wb_en && (wb_addr == ra_s[i])) begin
            // Returning load data is visible now and the register is no
            // longer waiting for it.
            rd_data[i*WIDTH +: WIDTH] = wb_data;
            rd_pending[i]             = 1'b0;
         end else if (BYPASS && wa_en && (wa_addr == ra_s[i])) begin
            rd_data[i*WIDTH +: WIDTH] = wa_data;
            rd_pending[i]             = pending_q[ra_s[i]];
         end else begin
            rd_data[i*WIDTH +: WIDTH] = regs_q[ra_s[i]];
            rd_pending[i]             = pending_q[ra_s[i]];
         end
      end
   end

   // Stall is forced low in reset so decode never sees a stale refusal.
   always_comb begin
      issue_stall = rst_n && issue_stall_s;
      hazard_err  = hazard_q;
   end

endmodule

// File: doc/rf_param.md
Name: rf_param

Overview:
- Parametrised successor to the CPU's fixed 8x16 single-write register file.
- Configurable width, depth and number of read ports.
- Two write ports: A for ALU writeback, B for load/late writeback. Optional zero-register, optional write-through bypass.
- Per-register pending scoreboard so the decode stage can stall on outstanding loads. Sits between decode (read/issue) and writeback.

Parameters:
- WIDTH, 16, data width in bits (>=1)
- DEPTH, 8, number of registers (power of 2, >=2); AW = clog2(DEPTH)
- NREAD, 2, number of read ports (>=1)
- ZERO_REG, 0, 1 = register 0 reads 0, ignores writes, never pending
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NREAD*AW  read addresses, port i at bits [i*AW +: AW]
- rd_data  out  NREAD*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
- rd_pending  out  NREAD  register at rd_addr[i] has an outstanding load
- wa_en  in  1  write port A enable (ALU)
- wa_addr  in  AW  write port A address
- wa_data  in  WIDTH  write port A data
- wb_en  in  1  write port B enable (load return); clears pending
- wb_addr  in  AW  write port B address
- wb_data  in  WIDTH  write port B data
- issue_en  in  1  request to mark issue_addr pending (load issued)
- issue_addr  in  AW  register targeted by the load
- issue_stall  out  1  issue refused: target already pending and not cleared this cycle
- hazard_err  out  1  sticky: port A wrote a pending register

Behaviour:
- Reset (async, rst_n=0):
  - all registers = 0; all pending bits = 0; hazard_err = 0.
  - While in reset, rd_data = 0, rd_pending = 0, issue_stall = 0.
- Reads are combinational, with no latency.
  - BYPASS=0: rd_data[i] = stored value.
  - BYPASS=1: if wb_en && wb_addr==rd_addr[i], return wb_data; else if wa_en && wa_addr==rd_addr[i], return wa_data; else return stored value.
- Writes take effect at the rising edge. If wa_en && wb_en && wa_addr==wb_addr, port B wins and port A is discarded.
- ZERO_REG=1:
  - Reads of address 0 return 0, including the bypass path.
  - Writes to address 0 are dropped.
  - issue to address 0 is accepted but sets nothing; issue_stall = 0.
  - rd_pending for address 0 is always 0.
- Scoreboard, next pending[r]:
  - Set if issue_en && issue_addr==r && !issue_stall.
  - Else cleared if wb_en && wb_addr==r.
  - Else held.
  - Issue and clear of the same register in the same cycle: the register ends pending (the new load owns it). The old value is written from wb_data.
- issue_stall = issue_en && pending[issue_addr] && !(wb_en && wb_addr==issue_addr). A stalled issue changes no state.
- rd_pending[i] = pending[rd_addr[i]] && !(wb_en && wb_addr==rd_addr[i]) when BYPASS=1. When BYPASS=0 the wb term is omitted.
- hazard_err sets at an edge where wa_en && pending[wa_addr] && !(wb_en && wb_addr==wa_addr). It then holds until reset. Port A's write is still performed.
- Address wrap: all addresses are AW bits, so no out-of-range case exists.
- Reset asserted mid-operation clears everything immediately, with no dependence on clk.

Test Plan:
- Reset then read all: assert rst_n=0 mid-run with registers holding 0x1234 -> rd_data = 0 and rd_pending = 0 immediately. After release, all reads return 0x0000.
- Dual write collision: same cycle wa(3, 0xAAAA) and wb(3, 0x5555) -> next cycle reg3 = 0x5555. With BYPASS=1, same-cycle read of 3 = 0x5555.
- Zero register (ZERO_REG=1): wa(0, 0xFFFF) -> read of 0 = 0x0000, including during the write cycle. issue(0) -> no stall, rd_pending stays 0.
- Scoreboard flow:
  - issue(5) -> rd_pending for 5 = 1.
  - Second issue(5) -> issue_stall = 1, state unchanged.
  - wb(5, 0x00C3) with issue(5) in the same cycle -> no stall, reg5 = 0x00C3, still pending.
  - wb(5) alone -> pending cleared.
- Hazard: issue(2), then wa(2, 0x0001) without wb -> hazard_err = 1 next cycle and stays 1, reg2 = 0x0001. wa with simultaneous wb(2) -> no error.
- Parameter sweep: WIDTH=32, DEPTH=16, NREAD=3, BYPASS=0 -> three independent reads of different addresses correct. A same-cycle write is not visible until the next cycle.
